// File: rtl/unpadding_pkg.sv
// ============================================================================
// unpadding_pkg : shared frame geometry defaults and row-phase encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package unpadding_pkg;

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_WIDTH  = 416;
  localparam int DEF_HEIGHT = 416;
  localparam int DEF_PAD    = 1;

  typedef enum logic [1:0] {
    ST_TOP  = 2'd0,
    ST_BODY = 2'd1,
    ST_BOT  = 2'd2
  } state_t;

  // Phase of a padded row index within the frame
  function automatic state_t row_state(input int row, input int pad, input int height);
    if (row < pad)
      return ST_TOP;
    else if (row < pad + height)
      return ST_BODY;
    else
      return ST_BOT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/unpadding_pad_border_check.sv
// ============================================================================
// pad_border_check : flags nonzero pixels in pad positions of one channel row
// Revision: 1.0
// ============================================================================
`default_nettype none

module pad_border_check
  import unpadding_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int WIDTH = DEF_WIDTH,
  parameter int PAD   = DEF_PAD
) (
  input  logic [(WIDTH+2*PAD)*PIX_W-1:0] row,
  input  state_t                         row_type,
  output logic                           border_nonzero
);

  localparam int C_ROW_W  = (WIDTH + 2*PAD) * PIX_W;
  localparam int C_EDGE_W = PAD * PIX_W;

  logic w_left;
  logic w_right;
  logic w_any;

  assign w_left  = |row[C_EDGE_W-1:0];
  assign w_right = |row[C_ROW_W-1 -: C_EDGE_W];
  assign w_any   = |row;

  // Pad rows must be entirely zero; body rows only at their edge columns
  assign border_nonzero = (row_type == ST_BODY) ? (w_left | w_right) : w_any;

endmodule

`default_nettype wire

// File: rtl/unpadding.sv
// ============================================================================
// unpadding : strips pad rows/columns from a padded RGB row stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module unpadding
  import unpadding_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int PAD    = DEF_PAD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_eof,
  input  logic [(WIDTH+2*PAD)*PIX_W-1:0] R_in,
  input  logic [(WIDTH+2*PAD)*PIX_W-1:0] G_in,
  input  logic [(WIDTH+2*PAD)*PIX_W-1:0] B_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH*PIX_W-1:0]       R_out,
  output logic [WIDTH*PIX_W-1:0]       G_out,
  output logic [WIDTH*PIX_W-1:0]       B_out,
  output logic [8:0]                   out_row,
  output logic                         out_last,
  output logic                         frame_err,
  output logic                         pad_err
);

  localparam int C_TOTAL_ROWS = HEIGHT + 2*PAD;
  localparam int C_ROW_W      = $clog2(C_TOTAL_ROWS);
  localparam int C_OUT_W      = WIDTH * PIX_W;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_ROW_W-1:0]   r_in_row;
  logic [C_ROW_W-1:0]   w_row_nxt;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_is_last;
  logic                 w_frame_err;
  logic [2:0]           w_border;

  logic                 r_out_valid;
  logic [C_OUT_W-1:0]   r_r_out;
  logic [C_OUT_W-1:0]   r_g_out;
  logic [C_OUT_W-1:0]   r_b_out;
  logic [8:0]           r_out_row;
  logic                 r_out_last;
  logic                 r_frame_err;
  logic                 r_pad_err;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_load    = w_accept && (r_state == ST_BODY);
  assign w_is_last = (r_in_row == C_ROW_W'(C_TOTAL_ROWS - 1));

  pad_border_check #(.PIX_W(PIX_W), .WIDTH(WIDTH), .PAD(PAD)) u_chk_r (
    .row(R_in), .row_type(r_state), .border_nonzero(w_border[0])
  );
  pad_border_check #(.PIX_W(PIX_W), .WIDTH(WIDTH), .PAD(PAD)) u_chk_g (
    .row(G_in), .row_type(r_state), .border_nonzero(w_border[1])
  );
  pad_border_check #(.PIX_W(PIX_W), .WIDTH(WIDTH), .PAD(PAD)) u_chk_b (
    .row(B_in), .row_type(r_state), .border_nonzero(w_border[2])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_TOP;
      r_in_row <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_row <= w_row_nxt;
    end
  end

  // Any eof/last-row disagreement ends the frame and raises frame_err
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_in_row;
    w_frame_err = 1'b0;
    if (w_accept) begin
      if (in_eof || w_is_last) begin
        w_row_nxt   = '0;
        w_state_nxt = ST_TOP;
        w_frame_err = in_eof ^ w_is_last;
      end else begin
        w_row_nxt   = r_in_row + 1'b1;
        w_state_nxt = row_state(int'(w_row_nxt), PAD, HEIGHT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_r_out     <= '0;
      r_g_out     <= '0;
      r_b_out     <= '0;
      r_out_row   <= '0;
      r_out_last  <= 1'b0;
      r_frame_err <= 1'b0;
      r_pad_err   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      if (w_accept && (|w_border))
        r_pad_err <= 1'b1;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_r_out     <= R_in[PAD*PIX_W +: C_OUT_W];
        r_g_out     <= G_in[PAD*PIX_W +: C_OUT_W];
        r_b_out     <= B_in[PAD*PIX_W +: C_OUT_W];
        r_out_row   <= 9'(r_in_row - C_ROW_W'(PAD));
        r_out_last  <= (r_in_row == C_ROW_W'(PAD + HEIGHT - 1));
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign R_out     = r_r_out;
  assign G_out     = r_g_out;
  assign B_out     = r_b_out;
  assign out_row   = r_out_row;
  assign out_last  = r_out_last;
  assign frame_err = r_frame_err;
  assign pad_err   = r_pad_err;

endmodule

`default_nettype wire

// File: tb/tb_unpadding.sv
// ============================================================================
// tb_unpadding : directed scoreboard bench for the unpadding row stripper
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unpadding;

  localparam int PIX_W  = 8;
  localparam int WIDTH  = 416;
  localparam int HEIGHT = 416;
  localparam int PAD    = 1;
  localparam int IW     = (WIDTH + 2*PAD) * PIX_W;
  localparam int OW     = WIDTH * PIX_W;
  localparam int TOTAL  = HEIGHT + 2*PAD;

  typedef struct {
    logic [8:0]    row;
    logic          last;
    logic [OW-1:0] r;
    logic [OW-1:0] g;
    logic [OW-1:0] b;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_eof;
  logic [IW-1:0] R_in, G_in, B_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] R_out, G_out, B_out;
  logic [8:0]    out_row;
  logic          out_last;
  logic          frame_err;
  logic          pad_err;

  exp_t q[$];
  int   vectors = 0;
  int   fails   = 0;
  int   mr      = 0;
  int   ticks   = 0;
  int   pops    = 0;
  int   stall_left  = 0;
  bit   stall_armed = 0;
  bit   cur_viol    = 0;
  bit   exp_ferr    = 0;
  bit   exp_perr    = 0;
  logic [OW-1:0] zero_row = '0;

  unpadding #(.PIX_W(PIX_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PAD(PAD)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_eof(in_eof),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .out_row(out_row), .out_last(out_last),
    .frame_err(frame_err), .pad_err(pad_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic a, input logic e);
    vectors++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, a, e);
    end
  endtask

  task automatic chk_int(input string tag, input int a, input int e);
    vectors++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, a, e);
    end
  endtask

  task automatic chk_row(input string tag, input logic [OW-1:0] a, input logic [OW-1:0] e);
    int k;
    vectors++;
    assert (a === e) else begin
      fails++;
      k = 0;
      for (int i = WIDTH-1; i >= 0; i--)
        if (a[i*PIX_W +: PIX_W] !== e[i*PIX_W +: PIX_W]) k = i;
      $error("FAIL %s: pixel %0d observed %h expected %h", tag, k,
             a[k*PIX_W +: PIX_W], e[k*PIX_W +: PIX_W]);
    end
  endtask

  function automatic exp_t make_exp(input int pr);
    exp_t e;
    e.row  = 9'(pr - PAD);
    e.last = ((pr - PAD) == HEIGHT - 1);
    for (int k = 0; k < WIDTH; k++) begin
      e.r[k*PIX_W +: PIX_W] = 8'(pr + k + 1);
      e.g[k*PIX_W +: PIX_W] = 8'(pr) ^ 8'(k + 1);
      e.b[k*PIX_W +: PIX_W] = 8'(pr);
    end
    return e;
  endfunction

  task automatic drive_row(input int pr, input bit viol);
    for (int j = 0; j < WIDTH + 2*PAD; j++) begin
      logic [7:0] rv, gv, bv;
      if (pr >= PAD && pr < PAD + HEIGHT && j >= PAD && j < PAD + WIDTH) begin
        rv = 8'(pr + j);
        gv = 8'(pr) ^ 8'(j);
        bv = 8'(pr);
      end else begin
        rv = 8'h00; gv = 8'h00; bv = 8'h00;
      end
      R_in[j*PIX_W +: PIX_W] = rv;
      G_in[j*PIX_W +: PIX_W] = gv;
      B_in[j*PIX_W +: PIX_W] = bv;
    end
    if (viol) R_in[7:0] = 8'h01;
  endtask

  // One clock: check DUT against the model, advance the model, pick out_ready
  task automatic tick(output bit acc);
    bit nf, np, last;
    @(negedge clk);
    chk1("out_valid", out_valid, q.size() != 0);
    chk1("in_ready", in_ready, (q.size() == 0) || out_ready);
    chk1("frame_err", frame_err, exp_ferr);
    chk1("pad_err", pad_err, exp_perr);
    if (q.size() != 0) begin
      chk_int("out_row", int'(out_row), int'(q[0].row));
      chk1("out_last", out_last, q[0].last);
      chk_row("R_out", R_out, q[0].r);
      chk_row("G_out", G_out, q[0].g);
      chk_row("B_out", B_out, q[0].b);
    end
    acc = in_valid && ((q.size() == 0) || out_ready);
    if (q.size() != 0 && out_ready) begin
      void'(q.pop_front());
      pops++;
    end
    nf = 1'b0;
    np = 1'b0;
    if (acc) begin
      if (mr >= PAD && mr < PAD + HEIGHT) q.push_back(make_exp(mr));
      np   = cur_viol;
      last = (mr == TOTAL - 1);
      if (in_eof || last) begin
        nf = in_eof ^ last;
        mr = 0;
      end else begin
        mr++;
      end
    end
    @(posedge clk);
    #1;
    exp_ferr = nf;
    exp_perr = exp_perr | np;
    ticks++;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (stall_armed && q.size() != 0 && q[0].row == 9'd10) begin
      out_ready   = 1'b0;
      stall_left  = 4;
      stall_armed = 1'b0;
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic send_row(input bit eof, input bit viol);
    bit acc;
    int guard;
    drive_row(mr, viol);
    cur_viol = viol;
    in_eof   = eof;
    in_valid = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      tick(acc);
      guard++;
    end
    chk1("row_accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
    in_eof   = 1'b0;
    cur_viol = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_eof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    mr       = 0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    chk1("rst_pad_err", pad_err, 1'b0);
    chk_int("rst_out_row", int'(out_row), 0);
    chk_row("rst_R_out", R_out, zero_row);
  endtask

  initial begin
    int t0, p0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_eof    = 1'b0;
    out_ready = 1'b1;
    R_in = '0; G_in = '0; B_in = '0;
    do_reset(2);
    idle(2);

    // partial frame, then reset with a row still held
    for (int r = 0; r < 6; r++) send_row(1'b0, 1'b0);
    do_reset(2);

    // full frame with a 5-cycle stall while row 10 is held
    stall_armed = 1'b1;
    t0 = ticks;
    p0 = pops;
    for (int r = 0; r < TOTAL; r++) send_row(r == TOTAL - 1, 1'b0);
    chk_int("frame_cycles", ticks - t0, TOTAL + 5);
    idle(1);
    chk_int("frame_outputs", pops - p0, HEIGHT);

    // early eof on padded row 200, then a frame ending without eof
    for (int r = 0; r <= 200; r++) send_row(r == 200, 1'b0);
    idle(1);
    chk_int("restart_row", mr, 0);
    for (int r = 0; r < TOTAL; r++) send_row(1'b0, 1'b0);
    idle(2);

    // nonzero pixel in the top pad row
    send_row(1'b0, 1'b1);
    for (int r = 0; r < 4; r++) send_row(1'b0, 1'b0);
    idle(3);
    do_reset(2);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
